// File: rtl/testdrive_axi4_stream_writer.sv
// rtl/testdrive_axi4_stream_writer.sv - drains a valid/ready stream into memory as AXI4 INCR write bursts
module testdrive_axi4_stream_writer #(
    parameter int C_THREAD_ID_WIDTH = 1,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_MAX_BURST       = 16,
    parameter int C_COUNT_WIDTH     = 16
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         START,
    input  logic [C_ADDR_WIDTH-1:0]      ADDR,
    input  logic [C_COUNT_WIDTH-1:0]     COUNT,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         ERROR,
    input  logic [C_DATA_WIDTH-1:0]      S_DATA,
    input  logic                         S_VALID,
    output logic                         S_READY,
    output logic [C_THREAD_ID_WIDTH-1:0] AWID,
    output logic [C_ADDR_WIDTH-1:0]      AWADDR,
    output logic [7:0]                   AWLEN,
    output logic [2:0]                   AWSIZE,
    output logic [1:0]                   AWBURST,
    output logic                         AWLOCK,
    output logic [3:0]                   AWCACHE,
    output logic [2:0]                   AWPROT,
    output logic [3:0]                   AWREGION,
    output logic [3:0]                   AWQOS,
    output logic                         AWVALID,
    input  logic                         AWREADY,
    output logic [C_THREAD_ID_WIDTH-1:0] WID,
    output logic [C_DATA_WIDTH-1:0]      WDATA,
    output logic [C_DATA_WIDTH/8-1:0]    WSTRB,
    output logic                         WLAST,
    output logic                         WVALID,
    input  logic                         WREADY,
    input  logic [C_THREAD_ID_WIDTH-1:0] BID,
    input  logic [1:0]                   BRESP,
    input  logic                         BVALID,
    output logic                         BREADY
);
    localparam int SIZE = $clog2(C_DATA_WIDTH / 8);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t                    state, state_next;
    logic [C_ADDR_WIDTH-1:0]   cur_addr, ld_addr, addr_inc;
    logic [C_COUNT_WIDTH-1:0]  remaining, ld_rem, beat_cnt;
    logic [8:0]                burst_len, ld_len;
    logic                      aw_load, finish, w_hs, b_hs, last_beat;
    logic                      unused_bid;

    // Burst length: capped by max burst, beats left, and beats until the next 4 KB page.
    function automatic logic [8:0] calc_len(input logic [11:0] a_lo, input logic [C_COUNT_WIDTH-1:0] r);
        logic [12:0] to_4k;
        logic [31:0] l;
        to_4k = (13'd4096 - {1'b0, a_lo}) >> SIZE;
        l = 32'(C_MAX_BURST);
        if (32'(to_4k) < l) l = 32'(to_4k);
        if (32'(r) < l) l = 32'(r);
        return 9'(l);
    endfunction

    assign unused_bid = ^BID;
    assign last_beat  = (beat_cnt == C_COUNT_WIDTH'(1));
    assign w_hs       = (state == ST_W) && S_VALID && WREADY;
    assign b_hs       = (state == ST_B) && BVALID && BREADY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        aw_load    = 1'b0;
        finish     = 1'b0;
        addr_inc   = C_ADDR_WIDTH'(burst_len) << SIZE;
        ld_addr    = cur_addr + addr_inc;
        ld_rem     = remaining;
        case (state)
            ST_IDLE: begin
                ld_addr = ADDR;
                ld_rem  = COUNT;
                if (START) begin
                    if (COUNT == '0) begin
                        finish = 1'b1;
                    end else begin
                        aw_load    = 1'b1;
                        state_next = ST_AW;
                    end
                end
            end
            ST_AW: if (AWREADY) state_next = ST_W;
            ST_W:  if (w_hs && last_beat) state_next = ST_B;
            ST_B: begin
                if (b_hs) begin
                    if (remaining == '0) begin
                        finish     = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        aw_load    = 1'b1;
                        state_next = ST_AW;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ld_len = calc_len(ld_addr[11:0], ld_rem);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWVALID   <= 1'b0;
            BREADY    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            DONE <= finish;
            if (state == ST_IDLE && START) begin
                ERROR     <= 1'b0;
                cur_addr  <= ADDR;
                remaining <= COUNT;
            end
            if (aw_load) begin
                AWADDR    <= ld_addr;
                AWLEN     <= 8'(ld_len - 9'd1);
                burst_len <= ld_len;
                AWVALID   <= 1'b1;
                BUSY      <= 1'b1;
            end
            if (state == ST_AW && AWREADY) begin
                AWVALID  <= 1'b0;
                beat_cnt <= C_COUNT_WIDTH'(burst_len);
            end
            if (w_hs) begin
                beat_cnt  <= beat_cnt - C_COUNT_WIDTH'(1);
                remaining <= remaining - C_COUNT_WIDTH'(1);
                if (last_beat) BREADY <= 1'b1;
            end
            // A bad response is recorded but the command keeps going.
            if (b_hs) begin
                BREADY   <= 1'b0;
                cur_addr <= ld_addr;
                if (BRESP != 2'b00) ERROR <= 1'b1;
                if (finish) BUSY <= 1'b0;
            end
        end
    end

    assign AWID     = '0;
    assign AWSIZE   = 3'(SIZE);
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'b0011;
    assign AWPROT   = 3'b000;
    assign AWREGION = 4'b0000;
    assign AWQOS    = 4'b0000;
    assign WID      = '0;
    assign WSTRB    = '1;
    assign WVALID   = (state == ST_W) && S_VALID;
    assign S_READY  = (state == ST_W) && WREADY;
    assign WDATA    = (state == ST_W) ? S_DATA : '0;
    assign WLAST    = (state == ST_W) && last_beat;
endmodule

// File: tb/tb_testdrive_axi4_stream_writer.sv
// tb/tb_testdrive_axi4_stream_writer.sv - scoreboard bench for the AXI4 stream writer
module tb_testdrive_axi4_stream_writer;
    logic         CLK = 1'b0;
    logic         nRST;
    logic         START;
    logic [31:0]  ADDR;
    logic [15:0]  COUNT;
    logic         BUSY, DONE, ERROR;
    logic [127:0] S_DATA;
    logic         S_VALID, S_READY;
    logic [0:0]   AWID, WID, BID;
    logic [31:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE, AWPROT;
    logic [1:0]   AWBURST, BRESP;
    logic         AWLOCK, AWVALID, AWREADY;
    logic [3:0]   AWCACHE, AWREGION, AWQOS;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST, WVALID, WREADY, BVALID, BREADY;

    always #5 CLK = ~CLK;

    testdrive_axi4_stream_writer dut (
        .CLK(CLK), .nRST(nRST), .START(START), .ADDR(ADDR), .COUNT(COUNT),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWREGION(AWREGION),
        .AWQOS(AWQOS), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    int           total = 0;
    int           bad = 0;
    logic [31:0]  exp_aw_addr[$];
    logic [7:0]   exp_aw_len[$];
    logic [127:0] exp_wd[$];
    logic         exp_wl[$];
    logic [127:0] src_q[$];
    logic [1:0]   bresp_q[$];
    int           w_beats = 0;
    int           aw_any = 0;
    int           slv_beats = 0;
    int           stall_at = 0;
    bit           gap_en = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push_burst(input logic [31:0] a, input int n, input logic [1:0] br);
        logic [127:0] d;
        exp_aw_addr.push_back(a);
        exp_aw_len.push_back(8'(n - 1));
        bresp_q.push_back(br);
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            src_q.push_back(d);
            exp_wd.push_back(d);
            exp_wl.push_back(i == n - 1);
        end
    endtask

    // Scoreboard monitor: compares every AW and W handshake against the queued expectations.
    always @(negedge CLK) begin
        if (nRST) begin
            if (AWVALID) aw_any++;
            if (AWVALID && AWREADY) begin
                if (exp_aw_addr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL aw_unexpected act=%h exp=none", AWADDR);
                end else begin
                    chk("awaddr", AWADDR, exp_aw_addr.pop_front());
                    chk("awlen", AWLEN, exp_aw_len.pop_front());
                    chk("awsize_burst", {AWSIZE, AWBURST}, {3'd4, 2'b01});
                end
            end
            if (WVALID && WREADY) begin
                w_beats++;
                if (exp_wd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL w_unexpected act=%h exp=none", WDATA);
                end else begin
                    chk("wdata", WDATA, exp_wd.pop_front());
                    chk("wlast", WLAST, exp_wl.pop_front());
                end
            end
        end
    end

    // Memory-side responder: WREADY stall window and one B response per WLAST.
    initial begin
        bit whs, wl, bh;
        int wstall;
        wstall = 0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00; BID = '0;
        forever begin
            @(negedge CLK);
            whs = WVALID && WREADY;
            wl  = whs && WLAST;
            bh  = BVALID && BREADY;
            @(posedge CLK); #1;
            if (!nRST) begin
                BVALID = 1'b0; WREADY = 1'b1; wstall = 0;
            end else begin
                if (whs) begin
                    slv_beats++;
                    if (slv_beats == stall_at) wstall = 3;
                end
                WREADY = (wstall == 0);
                if (wstall > 0) wstall--;
                if (bh) BVALID = 1'b0;
                if (wl) begin
                    BVALID = 1'b1;
                    BRESP = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                end
            end
        end
    end

    // Stream source with optional random gaps.
    initial begin
        bit hs;
        S_VALID = 1'b0; S_DATA = '0;
        forever begin
            @(negedge CLK);
            hs = S_VALID && S_READY;
            @(posedge CLK); #1;
            if (hs && src_q.size() > 0) src_q.delete(0);
            S_VALID = (src_q.size() > 0) && !(gap_en && $urandom_range(0, 2) == 0);
            S_DATA  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    task automatic issue_start(input logic [31:0] a, input logic [15:0] c);
        @(posedge CLK); #1;
        ADDR = a; COUNT = c; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] c, input logic exp_err);
        int  aw0;
        bit  got;
        aw0 = aw_any;
        issue_start(a, c);
        if (c == 0) begin
            chk("zc_done_cycle1", DONE, 1'b1);
            chk("zc_busy", BUSY, 1'b0);
        end else begin
            chk("start_busy", BUSY, 1'b1);
            chk("start_awvalid", AWVALID, 1'b1);
            chk("start_error_clr", ERROR, 1'b0);
            got = 0;
            for (int i = 0; i < 3000 && !got; i++) begin
                @(negedge CLK);
                got = DONE;
            end
            chk("done_seen", got, 1'b1);
            chk("done_error", ERROR, exp_err);
            chk("done_busy", BUSY, 1'b0);
        end
        @(negedge CLK);
        chk("done_pulse_width", DONE, 1'b0);
        chk("aw_left", exp_aw_addr.size(), 0);
        chk("w_left", exp_wd.size(), 0);
        if (c == 0) chk("zc_no_awvalid", aw_any - aw0, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {BUSY, DONE, ERROR, AWVALID, WVALID, BREADY, S_READY, WLAST}, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        nRST = 1'b0; START = 1'b0; ADDR = '0; COUNT = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_outputs_zero("reset");
        nRST = 1'b1;

        push_burst(32'h1000, 4, 2'b00);
        run_cmd(32'h1000, 16'd4, 1'b0);

        push_burst(32'h0000, 16, 2'b00);
        push_burst(32'h0100, 16, 2'b00);
        push_burst(32'h0200, 8, 2'b00);
        base = w_beats;
        run_cmd(32'h0000, 16'd40, 1'b0);
        chk("beats_40", w_beats - base, 40);

        push_burst(32'h0FC0, 4, 2'b00);
        push_burst(32'h1000, 4, 2'b00);
        run_cmd(32'h0FC0, 16'd8, 1'b0);

        push_burst(32'h2000, 16, 2'b10);
        push_burst(32'h2100, 16, 2'b00);
        run_cmd(32'h2000, 16'd32, 1'b1);

        gap_en = 1;
        stall_at = slv_beats + 6;
        push_burst(32'h3000, 16, 2'b00);
        push_burst(32'h3100, 4, 2'b00);
        base = w_beats;
        run_cmd(32'h3000, 16'd20, 1'b0);
        chk("beats_20", w_beats - base, 20);
        gap_en = 0;
        stall_at = 0;

        push_burst(32'h4000, 8, 2'b00);
        base = w_beats;
        issue_start(32'h4000, 16'd8);
        for (int i = 0; i < 200 && w_beats < base + 3; i++) @(negedge CLK);
        chk("mid_w_reached", (w_beats >= base + 3), 1'b1);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        exp_aw_addr.delete(); exp_aw_len.delete();
        exp_wd.delete(); exp_wl.delete();
        src_q.delete(); bresp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        push_burst(32'h5000, 2, 2'b00);
        run_cmd(32'h5000, 16'd2, 1'b0);

        run_cmd(32'h6000, 16'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/testdrive_axi4_stream_writer.md
# testdrive_axi4_stream_writer

Simulation-side AXI4 write master that drains a valid/ready data stream into memory as AXI4 INCR write bursts. It sits directly upstream of the team's AXI4 DPI slave BFM, driving its AW/W/B channels. It lets testbenches and DUT-side data producers write host memory without hand-writing AXI sequencing. One burst is outstanding at a time. Every burst respects the 4 KB boundary rule.

## Interface
- C_THREAD_ID_WIDTH, 1, width of AWID/WID/BID
- C_ADDR_WIDTH, 32, address width
- C_DATA_WIDTH, 128, data width; power of 2, 32..1024
- C_MAX_BURST, 16, maximum beats per burst; power of 2, 1..256
- C_COUNT_WIDTH, 16, width of COUNT and the remaining-beat counter

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low, single clock domain
- START  in  1  command strobe; sampled only in IDLE
- ADDR  in  C_ADDR_WIDTH  start byte address; aligned to C_DATA_WIDTH/8
- COUNT  in  C_COUNT_WIDTH  total beats; 0 is legal
- BUSY  out  1  a command is in progress
- DONE  out  1  one-cycle completion pulse
- ERROR  out  1  sticky; set when any BRESP != 0; cleared by an accepted START
- S_DATA  in  C_DATA_WIDTH  stream data
- S_VALID  in  1  stream valid
- S_READY  out  1  stream ready
- AWID, AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWLOCK, AWCACHE[3:0], AWPROT[2:0], AWREGION[3:0], AWQOS[3:0], AWVALID  out  write address channel
- AWREADY  in  1
- WID, WDATA, WSTRB, WLAST, WVALID  out  write data channel
- WREADY  in  1
- BID[C_THREAD_ID_WIDTH-1:0], BRESP[1:0], BVALID  in  write response channel
- BREADY  out  1

## Operation
**Constants**
- AWSIZE = log2(C_DATA_WIDTH/8); AWBURST = 2'b01.
- AWCACHE = 4'b0011.
- AWID, WID, AWLOCK, AWPROT, AWREGION, AWQOS = 0.
- WSTRB = all ones.

**States:** IDLE, AW, W, B.
- **IDLE:** START=1 latches ADDR into cur_addr and COUNT into remaining, and clears ERROR.
  - COUNT=0: go to IDLE and pulse DONE. No AXI traffic.
  - Otherwise: go to AW.
- **AW:** len = min(C_MAX_BURST, remaining, beats_to_4k).
  - beats_to_4k = (4096 - cur_addr[11:0]) >> AWSIZE.
  - AWADDR = cur_addr; AWLEN = len-1; AWVALID=1.
  - On AWVALID&&AWREADY: beat counter = len, go to W.
  - AW fields stay stable while AWVALID=1.
- **W:** pass-through of the stream.
  - WVALID = S_VALID; S_READY = WREADY; WDATA = S_DATA; WLAST = (beat counter == 1).
  - Each WVALID&&WREADY decrements the beat counter and remaining.
  - On the handshake with WLAST=1: go to B.
- **B:** BREADY=1.
  - On BVALID: if BRESP != 0, set ERROR. BID is ignored.
  - cur_addr += len << AWSIZE.
  - If remaining == 0: go to IDLE and pulse DONE. Otherwise go to AW.
- **Error policy:** an error does not abort the command; the remaining bursts are still issued.
- **Outside W:** S_READY=0 and WVALID=0.
- **START outside IDLE:** ignored.
- **Counter width:** remaining and the beat counter are C_COUNT_WIDTH wide. len uses a 9-bit intermediate so C_MAX_BURST=256 does not overflow.

## Timing
- **Reset values:** all outputs 0, including BUSY, DONE, ERROR, AWVALID, WVALID, BREADY and S_READY. State returns to IDLE.
- **Reset mid-operation:** the reset takes effect immediately. The in-flight burst is abandoned; the BFM is reset by the same nRST.
- **Registered outputs:** AW outputs, BUSY, DONE, ERROR and BREADY.
- **Combinational outputs:** WVALID, WDATA and S_READY are combinational in W state. WLAST is decoded from the registered beat counter.
- **Start latency:** START sampled at edge 0 gives AWVALID=1 after edge 0 (cycle 1). BUSY=1 from cycle 1.
- **AW to W:** the AW handshake at edge n opens W state from cycle n+1.
- **W throughput:** one beat per cycle when S_VALID and WREADY are both high.
- **W to B:** the WLAST handshake at edge n gives BREADY=1 from cycle n+1.
- **B to next:** the B handshake at edge n gives either the next AWVALID or DONE=1 plus BUSY=0 in cycle n+1.
- **DONE width:** DONE is high for exactly one cycle.
- **ERROR update:** ERROR is valid in the same cycle as DONE.
- **Zero count:** COUNT=0 gives DONE in cycle 1 and BUSY stays 0.

## Test plan
1. ADDR=0x1000, COUNT=4, 128-bit data, BFM always ready → one burst: AWADDR=0x1000, AWLEN=3, AWSIZE=4. Four W beats in stream order, WLAST on beat 4. One DONE pulse; ERROR=0.
2. ADDR=0x0, COUNT=40 → three bursts:
   - 0x000 with AWLEN=15
   - 0x100 with AWLEN=15
   - 0x200 with AWLEN=7
   - Exactly 40 beats, then DONE.
3. ADDR=0x0FC0, COUNT=8 → two bursts, neither crossing the 4 KB boundary:
   - 0x0FC0 with AWLEN=3
   - 0x1000 with AWLEN=3
4. COUNT=32 with BRESP=2'b10 on the first burst → the second burst is still issued. DONE arrives with ERROR=1. The next START clears ERROR to 0.
5. Random S_VALID gaps plus WREADY held low for 3 cycles mid-burst → no beat lost or duplicated, and WDATA order matches the input stream.
6. Two further cases:
   - nRST=0 asserted during W state → all outputs 0 without a clock edge. A new START after release runs cleanly.
   - COUNT=0 → DONE in cycle 1 and AWVALID is never asserted.
